mr_wb_arb: RTL and testbench

// N-master to 1-slave pipelined Wishbone arbiter (B4 pipelined, STALL-based).

---
 rtl/mr_wb_arb.sv | 243 ++++++++++++++++++++++++
 tb/tb_mr_wb_arb.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mr_wb_arb.sv
// ---------------------------------------------------------------------------
// mr_wb_arb -- N-master to 1-slave Wishbone B4 pipelined arbiter.
//
// Merges several pipelined (STALL-based) Wishbone masters onto one slave.
// A master that wins arbitration owns the bus for its whole CYC burst; the
// arbiter counts accepted-but-unanswered strobes so ACK/ERR can be routed
// back to the owner and so the number in flight never exceeds MAX_OUTST.
// Dropping CYC mid-burst is a Wishbone abort: in-flight responses are
// forgotten and any late slave ACK/ERR is swallowed.
//
// Parameters
//   NMASTERS   number of master ports (>= 2)
//   AW         word address width
//   DW         data width, SEL is DW/8 bits
//   MAX_OUTST  max strobes in flight per burst (>= 1)
//   PRIO_MODE  0 = round-robin, 1 = fixed priority (index 0 highest)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m_cyc_i/stb_i/we_i       per-master control, bit i = master i
//   m_adr_i/dat_i/sel_i      per-master fields, slice i = [i*W +: W]
//   m_dat_o                  read data (meaningful only with own ACK)
//   m_ack_o/err_o/stall_o    per-master response / flow control
//   s_cyc_o/stb_o/we_o       slave control
//   s_adr_o/dat_o/sel_o      slave request fields from the owner
//   s_dat_i/ack_i/err_i/stall_i  slave response
// ---------------------------------------------------------------------------

// Per-master response steering: a master only ever sees its own ACK/ERR,
// and every master except the current owner is held off with STALL.
module mr_wb_arb_port #(
    parameter int GW  = 1,
    parameter int IDX = 0
) (
    input  logic          busy_i,
    input  logic [GW-1:0] g_i,
    input  logic          stall_i,   // slave stall or outstanding limit hit
    input  logic          ack_i,     // qualified response (BUSY and cnt>0)
    input  logic          err_i,
    output logic          stall_o,
    output logic          ack_o,
    output logic          err_o
);
    localparam logic [GW-1:0] ID = GW'(IDX);

    logic own;

    assign own     = busy_i & (g_i == ID);
    assign stall_o = ~own | stall_i;
    assign ack_o   = own & ack_i;
    assign err_o   = own & err_i;
endmodule

module mr_wb_arb #(
    parameter int NMASTERS  = 2,
    parameter int AW        = 30,
    parameter int DW        = 32,
    parameter int MAX_OUTST = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NMASTERS-1:0]      m_cyc_i,
    input  logic [NMASTERS-1:0]      m_stb_i,
    input  logic [NMASTERS-1:0]      m_we_i,
    input  logic [NMASTERS*AW-1:0]   m_adr_i,
    input  logic [NMASTERS*DW-1:0]   m_dat_i,
    input  logic [NMASTERS*DW/8-1:0] m_sel_i,
    output logic [DW-1:0]            m_dat_o,
    output logic [NMASTERS-1:0]      m_ack_o,
    output logic [NMASTERS-1:0]      m_err_o,
    output logic [NMASTERS-1:0]      m_stall_o,
    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [AW-1:0]            s_adr_o,
    output logic [DW-1:0]            s_dat_o,
    output logic [DW/8-1:0]          s_sel_o,
    input  logic [DW-1:0]            s_dat_i,
    input  logic                     s_ack_i,
    input  logic                     s_err_i,
    input  logic                     s_stall_i
);
    localparam int GW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int SW = DW / 8;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] g_q, g_d;          // current owner
    logic [GW-1:0] last_q, last_d;    // previous owner, round-robin pointer
    logic [CW-1:0] cnt_q, cnt_d;      // strobes accepted but not answered

    // Per-master fields viewed as packed arrays so the owner mux is a plain index.
    logic [NMASTERS-1:0][AW-1:0] adr_a;
    logic [NMASTERS-1:0][DW-1:0] dat_a;
    logic [NMASTERS-1:0][SW-1:0] sel_a;

    assign adr_a = m_adr_i;
    assign dat_a = m_dat_i;
    assign sel_a = m_sel_i;

    logic          busy;
    logic          own_cyc;
    logic          full;
    logic          accept;
    logic          resp_ok;
    logic          rsp_ack;
    logic          rsp_err;
    logic [GW-1:0] win;

    assign busy    = (state_q == BUSY);
    assign own_cyc = busy & m_cyc_i[g_q];
    // Limit uses the registered count only; a same-cycle response cannot
    // open the window, which keeps the stall path free of s_ack_i.
    assign full    = (cnt_q == CW'(MAX_OUTST));
    assign accept  = s_stb_o & ~s_stall_i;
    // Responses with nothing in flight, or while idle, are strays and dropped.
    assign resp_ok = busy & (cnt_q != '0);
    assign rsp_ack = resp_ok & s_ack_i;
    assign rsp_err = resp_ok & s_err_i;

    // ------------------------------------------------------------------
    // Winner select. Scanning downward makes the last hit the lowest index:
    // lo_win is the lowest requester overall, hi_win the lowest one above
    // the previous owner (round-robin wraps to lo_win when none exists).
    // ------------------------------------------------------------------
    always_comb begin
        logic [GW-1:0] lo_win;
        logic [GW-1:0] hi_win;
        logic          hi_found;
        lo_win   = '0;
        hi_win   = '0;
        hi_found = 1'b0;
        for (int i = NMASTERS - 1; i >= 0; i--) begin
            if (m_cyc_i[i]) begin
                lo_win = GW'(i);
                if (GW'(i) > last_q) begin
                    hi_win   = GW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        if (PRIO_MODE != 0)
            win = lo_win;
        else
            win = hi_found ? hi_win : lo_win;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= GW'(NMASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|m_cyc_i) begin
                    state_d = BUSY;
                    g_d     = win;
                end
            end
            BUSY: begin
                if (!m_cyc_i[g_q]) begin
                    // End of burst or abort: forget anything in flight and
                    // sit in IDLE for one cycle before the next grant.
                    state_d = IDLE;
                    cnt_d   = '0;
                    last_d  = g_q;
                end else if (accept && !(rsp_ack || rsp_err)) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (!accept && (rsp_ack || rsp_err)) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (slave side and shared read data)
    // ------------------------------------------------------------------
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_dat_o = '0;
        if (busy) begin
            // CYC follows the owner combinationally so a drop reaches the
            // slave in the same cycle; STB is never shown without CYC.
            s_cyc_o = own_cyc;
            s_stb_o = own_cyc & m_stb_i[g_q] & ~full;
            s_we_o  = m_we_i[g_q];
            s_adr_o = adr_a[g_q];
            s_dat_o = dat_a[g_q];
            s_sel_o = sel_a[g_q];
            m_dat_o = s_dat_i;
        end
    end

    // ------------------------------------------------------------------
    // Per-master STALL / ACK / ERR steering
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NMASTERS; i++) begin : g_port
        mr_wb_arb_port #(
            .GW  (GW),
            .IDX (i)
        ) u_port (
            .busy_i  (busy),
            .g_i     (g_q),
            .stall_i (s_stall_i | full),
            .ack_i   (rsp_ack),
            .err_i   (rsp_err),
            .stall_o (m_stall_o[i]),
            .ack_o   (m_ack_o[i]),
            .err_o   (m_err_o[i])
        );
    end
endmodule

// File: tb/tb_mr_wb_arb.sv
// Directed bench for mr_wb_arb: a round-robin instance (scoreboarded) and a
// fixed-priority instance sharing the same inputs.
module tb_mr_wb_arb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       m_cyc, m_stb, m_we;
    logic [1:0][29:0] m_adr;
    logic [1:0][31:0] m_dat;
    logic [1:0][3:0]  m_sel;
    logic [31:0]      s_dat_i;
    logic             s_ack_i, s_err_i, s_stall_i;

    logic [31:0] m_dat_o, fp_m_dat_o;
    logic [1:0]  m_ack_o, m_err_o, m_stall_o, fp_m_ack_o, fp_m_err_o, fp_m_stall_o;
    logic        s_cyc_o, s_stb_o, s_we_o, fp_s_cyc_o, fp_s_stb_o, fp_s_we_o;
    logic [29:0] s_adr_o, fp_s_adr_o;
    logic [31:0] s_dat_o, fp_s_dat_o;
    logic [3:0]  s_sel_o, fp_s_sel_o;

    mr_wb_arb #(.NMASTERS(2), .AW(30), .DW(32), .MAX_OUTST(4), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i)
    );

    mr_wb_arb #(.NMASTERS(2), .AW(30), .DW(32), .MAX_OUTST(4), .PRIO_MODE(1)) u_fp (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_dat_o(fp_m_dat_o), .m_ack_o(fp_m_ack_o), .m_err_o(fp_m_err_o), .m_stall_o(fp_m_stall_o),
        .s_cyc_o(fp_s_cyc_o), .s_stb_o(fp_s_stb_o), .s_we_o(fp_s_we_o),
        .s_adr_o(fp_s_adr_o), .s_dat_o(fp_s_dat_o), .s_sel_o(fp_s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i)
    );

    typedef struct packed {
        logic        we;
        logic [29:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } sreq_t;

    typedef struct packed {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] dat;
    } mrsp_t;

    sreq_t sq[$];
    mrsp_t mq[$];
    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mset(input int i, input logic cyc, input logic stb, input logic we,
                        input logic [29:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        m_cyc[i] = cyc; m_stb[i] = stb; m_we[i] = we;
        m_adr[i] = adr; m_dat[i] = dat; m_sel[i] = sel;
    endtask

    // Expect master i's currently driven request to be accepted by the slave.
    task automatic exp_acc(input int i);
        sreq_t r;
        r.we = m_we[i]; r.adr = m_adr[i]; r.dat = m_dat[i]; r.sel = m_sel[i];
        sq.push_back(r);
    endtask

    task automatic exp_rsp(input logic [1:0] ack, input logic [1:0] err, input logic [31:0] dat);
        mrsp_t r;
        r.ack = ack; r.err = err; r.dat = dat;
        mq.push_back(r);
    endtask

    // Monitor: slave-side accepts and master-side responses of the RR instance.
    task automatic monitor();
        sreq_t r;
        mrsp_t p;
        forever begin
            @(negedge clk);
            if (s_stb_o && !s_stall_i) begin
                if (sq.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL acc_unexpected: got accept adr=0x%0h, want none (t=%0t)", s_adr_o, $time);
                end else begin
                    r = sq.pop_front();
                    chk("acc_adr", 64'(s_adr_o), 64'(r.adr));
                    chk("acc_we",  64'(s_we_o),  64'(r.we));
                    chk("acc_dat", 64'(s_dat_o), 64'(r.dat));
                    chk("acc_sel", 64'(s_sel_o), 64'(r.sel));
                end
            end
            if (|m_ack_o || |m_err_o) begin
                if (mq.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL rsp_unexpected: got ack=%b err=%b, want none (t=%0t)", m_ack_o, m_err_o, $time);
                end else begin
                    p = mq.pop_front();
                    chk("rsp_ack", 64'(m_ack_o), 64'(p.ack));
                    chk("rsp_err", 64'(m_err_o), 64'(p.err));
                    chk("rsp_dat", 64'(m_dat_o), 64'(p.dat));
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    initial begin
        logic [29:0] aa [2];
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_stall_i = 1'b0;
        fork monitor(); join_none

        // ---- reset values ----
        #3;
        chk("rst_s_cyc",   64'(s_cyc_o),      64'(0));
        chk("rst_s_stb",   64'(s_stb_o),      64'(0));
        chk("rst_stall",   64'(m_stall_o),    64'(2'b11));
        chk("rst_fpstall", 64'(fp_m_stall_o), 64'(2'b11));
        chk("rst_ack",     64'(m_ack_o),      64'(0));
        chk("rst_adr",     64'(s_adr_o),      64'(0));
        chk("rst_cnt",     64'(u_rr.cnt_q),   64'(0));
        tick(); tick();
        rst = 1'b0;

        // ---- single read ----
        tick();
        mset(0, 1, 1, 0, 30'h10, 32'h0, 4'hF);
        #1 chk("rd_grant_latency", 64'(s_cyc_o), 64'(0));
        tick();
        chk("rd_s_cyc", 64'(s_cyc_o), 64'(1));
        chk("rd_s_stb", 64'(s_stb_o), 64'(1));
        chk("rd_stall", 64'(m_stall_o), 64'(2'b10));
        exp_acc(0);
        tick();
        mset(0, 1, 0, 0, 30'h10, 32'h0, 4'hF);
        #1 chk("rd_stb_drop", 64'(s_stb_o), 64'(0));
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
        exp_rsp(2'b01, 2'b00, 32'hDEADBEEF);
        #1 chk("rd_ack", 64'(m_ack_o), 64'(2'b01));
        tick();
        s_ack_i = 1'b0; s_dat_i = '0;
        mset(0, 0, 0, 0, 30'h0, 32'h0, 4'h0);
        #1 chk("rd_release_cyc", 64'(s_cyc_o), 64'(0));
        tick();

        // ---- round-robin vs fixed priority, fresh reset ----
        rst = 1'b1; tick(); rst = 1'b0;
        aa[0] = 30'h100; aa[1] = 30'h200;
        mset(0, 1, 1, 0, aa[0], 32'h0, 4'hF);
        mset(1, 1, 1, 0, aa[1], 32'h0, 4'hF);
        tick();
        for (int k = 0; k < 4; k++) begin
            int o;
            o = k % 2;
            chk($sformatf("rr_grant%0d", k), 64'(s_adr_o), 64'(aa[o]));
            chk($sformatf("rr_stb%0d", k), 64'(s_stb_o), 64'(1));
            chk($sformatf("rr_other_stall%0d", k), 64'(m_stall_o[1-o]), 64'(1));
            chk($sformatf("fp_m0_only%0d", k), 64'({fp_s_cyc_o, fp_s_adr_o}), 64'({1'b1, aa[0]}));
            exp_acc(o);
            tick();
            mset(o, 1, 0, 0, aa[o], 32'h0, 4'hF);
            s_ack_i = 1'b1; s_dat_i = 32'hA000_0000 + k;
            exp_rsp(2'(1 << o), 2'b00, 32'hA000_0000 + k);
            tick();
            s_ack_i = 1'b0;
            mset(o, 0, 0, 0, aa[o], 32'h0, 4'hF);
            tick();
            mset(o, 1, 1, 0, aa[o], 32'h0, 4'hF);
            #1 chk($sformatf("rr_idle_gap%0d", k), 64'(s_cyc_o), 64'(0));
            tick();
        end
        // RR now owns M0; M0 drops so fixed priority finally moves to M1.
        mset(0, 0, 0, 0, 30'h0, 32'h0, 4'h0);
        #1 chk("rr_m0_drop", 64'(s_cyc_o), 64'(0));
        tick();
        chk("fp_idle", 64'(fp_s_cyc_o), 64'(0));
        tick();
        chk("fp_m1_after_drop", 64'({fp_s_cyc_o, fp_s_adr_o}), 64'({1'b1, aa[1]}));
        chk("rr_m1_grant", 64'(s_adr_o), 64'(aa[1]));
        exp_acc(1);
        tick();
        mset(1, 1, 0, 0, aa[1], 32'h0, 4'hF);
        s_ack_i = 1'b1; s_dat_i = 32'h0000_B0B0;
        exp_rsp(2'b10, 2'b00, 32'h0000_B0B0);
        tick();
        s_ack_i = 1'b0;
        mset(1, 0, 0, 0, 30'h0, 32'h0, 4'h0);
        tick();

        // ---- outstanding limit, ack+accept, err ----
        mset(0, 1, 1, 0, 30'h300, 32'h0, 4'hF);
        tick();
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("ost_stb%0d", b), 64'(s_stb_o), 64'(1));
            exp_acc(0);
            tick();
            mset(0, 1, 1, 0, 30'(30'h301 + b), 32'h0, 4'hF);
        end
        #1;
        chk("ost_full_stall", 64'(m_stall_o[0]), 64'(1));
        chk("ost_full_nostb", 64'(s_stb_o), 64'(0));
        chk("ost_cnt4", 64'(u_rr.cnt_q), 64'(4));
        s_ack_i = 1'b1; s_dat_i = 32'h1111;
        exp_rsp(2'b01, 2'b00, 32'h1111);
        #1 chk("ost_ack_no_lift", 64'(m_stall_o[0]), 64'(1));
        tick();
        s_ack_i = 1'b0;
        #1;
        chk("ost_5th_stb", 64'(s_stb_o), 64'(1));
        chk("ost_5th_stall", 64'(m_stall_o[0]), 64'(0));
        exp_acc(0);
        tick();
        mset(0, 1, 0, 0, 30'h304, 32'h0, 4'hF);
        s_ack_i = 1'b1; s_dat_i = 32'h2222;
        exp_rsp(2'b01, 2'b00, 32'h2222);
        tick();
        s_dat_i = 32'h3333;
        exp_rsp(2'b01, 2'b00, 32'h3333);
        tick();
        chk("ost_cnt2", 64'(u_rr.cnt_q), 64'(2));
        mset(0, 1, 1, 1, 30'h305, 32'hCAFE0000, 4'h3);
        s_dat_i = 32'h4444;
        exp_rsp(2'b01, 2'b00, 32'h4444);
        exp_acc(0);
        tick();
        chk("ack_accept_cnt", 64'(u_rr.cnt_q), 64'(2));
        mset(0, 1, 0, 0, 30'h305, 32'h0, 4'hF);
        s_ack_i = 1'b0; s_err_i = 1'b1; s_dat_i = 32'h5555;
        exp_rsp(2'b00, 2'b01, 32'h5555);
        #1;
        chk("err_only_err", 64'(m_err_o), 64'(2'b01));
        chk("err_no_ack", 64'(m_ack_o), 64'(0));
        tick();
        s_err_i = 1'b0;
        mset(0, 0, 0, 0, 30'h0, 32'h0, 4'h0);
        tick();

        // ---- abort by M1 with 3 in flight ----
        mset(1, 1, 1, 0, 30'h400, 32'h0, 4'hF);
        tick();
        exp_acc(1);
        tick();
        mset(1, 1, 1, 0, 30'h401, 32'h0, 4'hF);
        exp_acc(1);
        tick();
        mset(1, 1, 1, 0, 30'h402, 32'h0, 4'hF);
        exp_acc(1);
        tick();
        chk("abort_cnt3", 64'(u_rr.cnt_q), 64'(3));
        mset(1, 0, 0, 0, 30'h0, 32'h0, 4'h0);
        mset(0, 1, 1, 0, 30'h500, 32'h0, 4'hF);
        #1 chk("abort_cyc_drop", 64'(s_cyc_o), 64'(0));
        tick();
        chk("abort_cnt0", 64'(u_rr.cnt_q), 64'(0));
        chk("abort_idle_cyc", 64'(s_cyc_o), 64'(0));
        chk("abort_idle_stall", 64'(m_stall_o), 64'(2'b11));
        s_ack_i = 1'b1; s_dat_i = 32'h6666;
        #1 chk("abort_stray_ack", 64'(m_ack_o), 64'(0));
        tick();
        chk("abort_m0_grant", 64'({s_cyc_o, s_adr_o}), 64'({1'b1, 30'h500}));
        chk("stray_ack_cnt0", 64'(m_ack_o), 64'(0));
        exp_acc(0);
        tick();
        s_ack_i = 1'b0;
        mset(0, 1, 1, 0, 30'h501, 32'h0, 4'hF);
        exp_acc(0);
        tick();

        // ---- async reset mid-burst ----
        chk("arst_cnt2", 64'(u_rr.cnt_q), 64'(2));
        mset(0, 1, 0, 0, 30'h501, 32'h0, 4'hF);
        mset(1, 1, 1, 0, 30'h600, 32'h0, 4'hF);
        s_dat_i = 32'h7777;
        #2 rst = 1'b1;
        #1;
        chk("arst_s_cyc", 64'(s_cyc_o), 64'(0));
        chk("arst_s_stb", 64'(s_stb_o), 64'(0));
        chk("arst_stall", 64'(m_stall_o), 64'(2'b11));
        chk("arst_ack", 64'(m_ack_o), 64'(0));
        chk("arst_dat", 64'(m_dat_o), 64'(0));
        chk("arst_adr", 64'(s_adr_o), 64'(0));
        chk("arst_cnt", 64'(u_rr.cnt_q), 64'(0));
        tick(); tick();
        rst = 1'b0;
        mset(0, 1, 1, 0, 30'h700, 32'h0, 4'hF);
        tick();
        chk("arst_first_m0", 64'({s_cyc_o, s_adr_o}), 64'({1'b1, 30'h700}));
        exp_acc(0);
        tick();
        mset(0, 1, 0, 0, 30'h700, 32'h0, 4'hF);
        s_ack_i = 1'b1;
        exp_rsp(2'b01, 2'b00, 32'h7777);
        tick();
        s_ack_i = 1'b0;
        mset(0, 0, 0, 0, 30'h0, 32'h0, 4'h0);
        mset(1, 0, 0, 0, 30'h0, 32'h0, 4'h0);
        tick(); tick();

        chk("sq_drain", 64'(sq.size()), 64'(0));
        chk("mq_drain", 64'(mq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
